// File: rtl/sysid_ext.sv
// sysid_ext - system identification register block on Avalon-MM.
//
// Reports a fixed system ID, build timestamp, version and clock frequency,
// plus a free-running 64-bit uptime counter and a read/write scratch word.
// Read data is registered (latency 1) and qualified by readdatavalid.
//
// Register map (word addresses):
//   0 ID          RO
//   1 TIMESTAMP   RO
//   2 VERSION     RO
//   3 CLK_FREQ_HZ RO
//   4 UPTIME_LO   RO  (also snapshots the upper counter half)
//   5 UPTIME_HI   RO  (returns the snapshot, not the live counter)
//   6 SCRATCH     RW
//   7, >=8        read as 0, writes ignored
//
// Ports:
//   clock         sole clock
//   reset_n       asynchronous active-low reset
//   address       word address, ADDR_W bits
//   read          read strobe, one cycle per transfer
//   write         write strobe
//   writedata     32-bit write data
//   readdata      32-bit registered read data, holds when not valid
//   readdatavalid readdata is valid this cycle
module sysid_ext #(
  parameter logic [31:0] ID           = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter logic [63:0] UPTIME_INIT  = 64'd0,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] CLK_FREQ_WORD = 32'(CLK_FREQ_HZ);

  logic [63:0] uptime;
  logic [31:0] uptime_hi_shadow;
  logic [31:0] scratch;
  logic [31:0] read_mux;
  logic        sel_lo;
  logic        sel_scratch;

  assign sel_lo      = (address == ADDR_W'(4));
  assign sel_scratch = (address == ADDR_W'(6));

  // Read mux works on the values before this edge's updates, so a read of
  // SCRATCH alongside a write returns the old word, and UPTIME_LO and the
  // shadow both come from the same pre-increment counter value.
  always_comb begin
    read_mux = 32'h0;
    case (address)
      ADDR_W'(0): read_mux = ID;
      ADDR_W'(1): read_mux = TIMESTAMP;
      ADDR_W'(2): read_mux = VERSION;
      ADDR_W'(3): read_mux = CLK_FREQ_WORD;
      ADDR_W'(4): read_mux = uptime[31:0];
      ADDR_W'(5): read_mux = uptime_hi_shadow;
      ADDR_W'(6): read_mux = scratch;
      default:    read_mux = 32'h0;
    endcase
  end

  // Free-running uptime counter; wraps silently at 2^64.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= UPTIME_INIT;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // Reading the low word captures the matching high word for a later read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_hi_shadow <= 32'h0;
    end else if (read && sel_lo) begin
      uptime_hi_shadow <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (write && sel_scratch) begin
      scratch <= writedata;
    end
  end

  // Registered read response; readdata holds its last value between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= read_mux;
      end
    end
  end

endmodule

// File: tb/tb_sysid_ext.sv
// tb_sysid_ext - directed, table-driven bench for sysid_ext.
module tb_sysid_ext;

  localparam logic [31:0] P_ID      = 32'h1234_5678;
  localparam logic [31:0] P_TS      = 32'h58BF_0010;
  localparam logic [31:0] P_VER     = 32'h0001_0000;
  localparam logic [31:0] P_FREQ    = 32'h02FA_F080;
  localparam logic [31:0] P_SCRATCH = 32'hA5A5_0001;
  localparam logic [63:0] P_UPTIME  = 64'h0000_0000_FFFF_FFFE;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int vec_count;
  int err_count;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  sysid_ext #(
    .ID          (P_ID),
    .TIMESTAMP   (P_TS),
    .VERSION     (P_VER),
    .CLK_FREQ_HZ (50_000_000),
    .SCRATCH_INIT(P_SCRATCH),
    .UPTIME_INIT (P_UPTIME),
    .ADDR_W      (3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr,
                                input logic [2:0] addr, input logic [31:0] wdata);
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = wdata;
  endtask

  task automatic check_output(input string name, input logic exp_valid,
                              input logic [31:0] exp_data);
    vec_count++;
    if (readdatavalid !== exp_valid || readdata !== exp_data) begin
      err_count++;
      $display("[TB] FAIL %s: got valid=%0b data=%08h, expected valid=%0b data=%08h",
               name, readdatavalid, readdata, exp_valid, exp_data);
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;

    // Constants, scratch read/write and RO write protection.
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0, 1'b1, P_ID,          "rd_id"};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 32'h0, 1'b1, P_TS,          "rd_ts"};
    vecs[2]  = '{1'b1, 1'b0, 3'd2, 32'h0, 1'b1, P_VER,         "rd_ver"};
    vecs[3]  = '{1'b1, 1'b0, 3'd3, 32'h0, 1'b1, P_FREQ,        "rd_freq"};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'h0, 1'b0, P_FREQ,        "idle_hold"};
    vecs[5]  = '{1'b0, 1'b1, 3'd6, 32'hDEAD_BEEF, 1'b0, P_FREQ, "wr_scratch"};
    vecs[6]  = '{1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_scratch"};
    vecs[7]  = '{1'b1, 1'b1, 3'd6, 32'h0, 1'b1, 32'hDEAD_BEEF, "rdwr_scratch"};
    vecs[8]  = '{1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'h0,         "rd_scratch_new"};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro0"};
    vecs[10] = '{1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro1"};
    vecs[11] = '{1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro2"};
    vecs[12] = '{1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro3"};
    vecs[13] = '{1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro4"};
    vecs[14] = '{1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro5"};
    vecs[15] = '{1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_ro7"};
    vecs[16] = '{1'b1, 1'b0, 3'd0, 32'h0, 1'b1, P_ID,          "rd_id_after"};
    vecs[17] = '{1'b1, 1'b0, 3'd1, 32'h0, 1'b1, P_TS,          "rd_ts_after"};
    vecs[18] = '{1'b1, 1'b0, 3'd2, 32'h0, 1'b1, P_VER,         "rd_ver_after"};
    vecs[19] = '{1'b1, 1'b0, 3'd3, 32'h0, 1'b1, P_FREQ,        "rd_freq_after"};
    vecs[20] = '{1'b1, 1'b0, 3'd7, 32'h0, 1'b1, 32'h0,         "rd_addr7"};
    vecs[21] = '{1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'h0,         "rd_scratch_kept"};
    vecs[22] = '{1'b1, 1'b0, 3'd5, 32'h0, 1'b1, 32'h1,         "rd_shadow_kept"};
    vecs[23] = '{1'b0, 1'b1, 3'd6, 32'h1357_9BDF, 1'b0, 32'h1, "wr_scratch2"};
    vecs[24] = '{1'b1, 1'b0, 3'd6, 32'h0, 1'b1, 32'h1357_9BDF, "rd_scratch2"};
    vecs[25] = '{1'b1, 1'b0, 3'd1, 32'h0, 1'b1, P_TS,          "rd_ts_last"};

    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    tick();
    check_output("reset_state", 1'b0, 32'h0);

    // Release between edges; the next edge is the first counter increment.
    reset_n = 1'b1;
    tick();
    check_output("no_read_yet", 1'b0, 32'h0);

    // Read at the 2nd edge sees counter INIT+1 = 0x0_FFFFFFFF.
    apply_stimulus(1'b1, 1'b0, 3'd4, 32'h0);
    tick();
    check_output("lo_pre_carry", 1'b1, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b0, 3'd5, 32'h0);
    tick();
    check_output("hi_pre_carry", 1'b1, 32'h0);

    // Edges 4..6 see counter 0x1_00000001 .. 0x1_00000003.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 3'd4, 32'h0);
      tick();
      check_output($sformatf("b2b_lo_%0d", i), 1'b1, 32'(i + 1));
    end
    apply_stimulus(1'b1, 1'b0, 3'd5, 32'h0);
    tick();
    check_output("hi_post_carry", 1'b1, 32'h1);
    apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    check_output("valid_pulse_end", 1'b0, 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      tick();
      check_output(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data);
    end

    // Reset asserted in the cycle a read is issued.
    apply_stimulus(1'b1, 1'b0, 3'd0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset", 1'b0, 32'h0);
    tick();
    check_output("held_in_reset", 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    reset_n = 1'b1;

    // Counter restarts at INIT; first edge after release sees INIT.
    apply_stimulus(1'b1, 1'b0, 3'd4, 32'h0);
    tick();
    check_output("restart_lo", 1'b1, 32'hFFFF_FFFE);
    apply_stimulus(1'b1, 1'b0, 3'd5, 32'h0);
    tick();
    check_output("restart_hi", 1'b1, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'd6, 32'h0);
    tick();
    check_output("scratch_init", 1'b1, P_SCRATCH);
    apply_stimulus(1'b1, 1'b0, 3'd4, 32'h0);
    tick();
    check_output("restart_lo_carry", 1'b1, 32'h1);
    apply_stimulus(1'b1, 1'b0, 3'd5, 32'h0);
    tick();
    check_output("restart_hi_carry", 1'b1, 32'h1);
    apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    check_output("final_idle", 1'b0, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
